// File: rtl/aes_dec_key_sched_if.sv
// Bundle between the key scheduler, the decipher datapath and the shared S-box.
interface aes_dec_key_sched_if;
  logic         init;
  logic [255:0] key;
  logic         keylen;
  logic [3:0]   round_key_addr;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  modport master (
    output init, key, keylen, round_key_addr, new_sboxw,
    input  round_key, ready, sboxw
  );

  modport slave (
    input  init, key, keylen, round_key_addr, new_sboxw,
    output round_key, ready, sboxw
  );
endinterface

// File: rtl/aes_dec_key_sched.sv
// Iterative AES round-key expander/store, one key per cycle via a shared S-box.
// Define AES_DEC_KEY_SCHED_256_EN for AES-256 keys and a 15-entry store.
module aes_dec_key_sched #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input logic clk,
  input logic reset,
  aes_dec_key_sched_if.slave bus
);

`ifdef AES_DEC_KEY_SCHED_256_EN
  localparam int NKEYS = 15;
`else
  localparam int NKEYS = 11;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_GEN,
    S_DONE
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_keys [NKEYS];
  logic [127:0] r_prev;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;

  logic         w_len;
  logic         w_use_rcon;
  logic         w_last;
  logic         w_accept;
  logic [127:0] w_base;
  logic [127:0] w_k0;
  logic [127:0] w_new;
  logic [127:0] w_rd;
  logic [31:0]  w_t;
  logic [31:0]  w_w0;
  logic [31:0]  w_w1;
  logic [31:0]  w_w2;
  logic [31:0]  w_w3;
  logic [7:0]   w_xrcon;

`ifdef AES_DEC_KEY_SCHED_256_EN
  logic [255:0] r_key;
  logic         r_len;
  logic [127:0] r_prev2;

  assign w_len  = r_len;
  assign w_k0   = r_key[255:128];
  assign w_base = r_len ? r_prev2 : r_prev;
`else
  logic [127:0] r_key;
  logic         w_unused;

  assign w_len    = 1'b0;
  assign w_k0     = r_key;
  assign w_base   = r_prev;
  assign w_unused = ^{bus.keylen, bus.key[127:0]};
`endif

  assign w_accept   = (r_state == S_IDLE) && bus.init;
  // Odd AES-256 rounds use plain SubWord without rotation or rcon
  assign w_use_rcon = !w_len || !r_rnd[0];
  assign w_last     = r_rnd == (w_len ? AES256_ROUNDS : AES128_ROUNDS);
  assign w_xrcon    = {r_rcon[6:0], 1'b0}
                    ^ (r_rcon[7] ? 8'h1b : 8'h00);

  assign bus.sboxw = w_use_rcon
                   ? {r_prev[23:0], r_prev[31:24]}
                   : r_prev[31:0];

  assign w_t  = bus.new_sboxw
              ^ (w_use_rcon ? {r_rcon, 24'h0} : 32'h0);
  assign w_w0 = w_base[127:96] ^ w_t;
  assign w_w1 = w_base[95:64]  ^ w_w0;
  assign w_w2 = w_base[63:32]  ^ w_w1;
  assign w_w3 = w_base[31:0]   ^ w_w2;
  assign w_new = {w_w0, w_w1, w_w2, w_w3};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.init) w_next = S_INIT;
      S_INIT:  w_next = S_GEN;
      S_GEN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key  <= '0;
      r_prev <= '0;
      r_rcon <= 8'h01;
      r_rnd  <= 4'd0;
`ifdef AES_DEC_KEY_SCHED_256_EN
      r_len   <= 1'b0;
      r_prev2 <= '0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifdef AES_DEC_KEY_SCHED_256_EN
            r_key <= bus.key;
            r_len <= bus.keylen;
`else
            r_key <= bus.key[255:128];
`endif
            r_rcon <= 8'h01;
            r_rnd  <= 4'd0;
          end
        end
        S_INIT: begin
`ifdef AES_DEC_KEY_SCHED_256_EN
          if (r_len) begin
            r_prev2 <= r_key[255:128];
            r_prev  <= r_key[127:0];
            r_rnd   <= 4'd2;
          end else begin
            r_prev <= r_key[255:128];
            r_rnd  <= 4'd1;
          end
`else
          r_prev <= r_key;
          r_rnd  <= 4'd1;
`endif
        end
        S_GEN: begin
          r_prev <= w_new;
`ifdef AES_DEC_KEY_SCHED_256_EN
          r_prev2 <= r_prev;
`endif
          r_rnd <= r_rnd + 4'd1;
          if (w_use_rcon) r_rcon <= w_xrcon;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NKEYS; i++) r_keys[i] <= '0;
    end else if (r_state == S_INIT) begin
      r_keys[0] <= w_k0;
`ifdef AES_DEC_KEY_SCHED_256_EN
      if (r_len) r_keys[1] <= r_key[127:0];
`endif
    end else if (r_state == S_GEN) begin
      for (int i = 0; i < NKEYS; i++) begin
        if (r_rnd == 4'(i)) r_keys[i] <= w_new;
      end
    end
  end

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < NKEYS; i++) begin
      if (bus.round_key_addr == 4'(i)) w_rd = r_keys[i];
    end
  end

  assign bus.round_key = w_rd;
  assign bus.ready     = (r_state == S_IDLE);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched: FIPS-197 vectors, corner sequences and
// random keys checked against a word-level key expansion model.
module tb_aes_dec_key_sched;

`ifdef AES_DEC_KEY_SCHED_256_EN
  localparam bit EN256 = 1'b1;
`else
  localparam bit EN256 = 1'b0;
`endif

  localparam logic [127:0] V128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] V256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] K1_128 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

  typedef struct {
    logic [255:0] key;
    bit           len;
    logic [3:0]   addr;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]   sbox [256];
  logic [127:0] m_keys [16];
  vec_t         vecs [6];

  aes_dec_key_sched_if bus();

  aes_dec_key_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.new_sboxw = {sbox[bus.sboxw[31:24]], sbox[bus.sboxw[23:16]],
                          sbox[bus.sboxw[15:8]],  sbox[bus.sboxw[7:0]]};

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      bb = bb >> 1;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  function automatic int lat_of(input bit l);
    return (EN256 && l) ? 15 : 12;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] r;
    logic [7:0] s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv;
      r = inv;
      repeat (4) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox[a] = s ^ 8'h63;
    end
  endtask

  task automatic model_clear();
    for (int a = 0; a < 16; a++) m_keys[a] = '0;
  endtask

  task automatic model_expand(input logic [255:0] k, input bit l);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nr;
    bit len;
    len = EN256 && l;
    nk = len ? 8 : 4;
    nr = len ? 14 : 10;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      m_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [255:0] k, input bit l);
    @(negedge clk);
    bus.init = 1'b1;
    bus.key = k;
    bus.keylen = l;
    @(posedge clk);
    #1;
    check("ready_fall", 128'(bus.ready), 128'd0);
    bus.init = 1'b0;
  endtask

  task automatic wait_ready(input string nm, input int done,
                            input int exp_lat);
    int n;
    n = done;
    forever begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ready) break;
      if (n >= 40) begin
        $display("FAIL %s_timeout got=%0d want=%0d", nm, n, exp_lat);
        errors++;
        break;
      end
    end
    check({nm, "_lat"}, 128'(n), 128'(exp_lat));
  endtask

  task automatic check_addrs(input string nm, input int lo, input int hi);
    for (int a = lo; a <= hi; a++) begin
      @(negedge clk);
      bus.round_key_addr = 4'(a);
      #1;
      check($sformatf("%s_a%0d", nm, a), bus.round_key, m_keys[a]);
    end
  endtask

  task automatic run(input string nm, input logic [255:0] k, input bit l);
    start(k, l);
    model_expand(k, l);
    wait_ready(nm, 0, lat_of(l));
  endtask

  initial begin
    logic [255:0] rk;
    bit rl;

    vecs[0] = '{{V128, 128'h0}, 1'b0, 4'd10,
                128'h13111d7fe3944a17f307a78b4d2b30c5, 12};
    vecs[1] = '{{V128, 128'h0}, 1'b0, 4'd0, V128, 12};
    vecs[2] = '{V256, 1'b1, 4'd14,
                EN256 ? 128'h24fc79ccbf0979e9371ac23c6d68de36 : 128'h0,
                EN256 ? 15 : 12};
    vecs[3] = '{V256, 1'b1, 4'd1,
                EN256 ? 128'h101112131415161718191a1b1c1d1e1f : K1_128,
                EN256 ? 15 : 12};
    vecs[4] = '{V256, 1'b1, 4'd15, 128'h0, EN256 ? 15 : 12};
    vecs[5] = '{{V128, 128'h0}, 1'b1, 4'd1,
                EN256 ? 128'h0 : K1_128, EN256 ? 15 : 12};

    reset = 1'b1;
    bus.init = 1'b0;
    bus.key = '0;
    bus.keylen = 1'b0;
    bus.round_key_addr = 4'd0;
    build_sbox();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 128'(bus.ready), 128'd1);
    check_addrs("reset", 0, 15);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start(vecs[i].key, vecs[i].len);
      wait_ready($sformatf("vec%0d", i), 0, vecs[i].lat);
      @(negedge clk);
      bus.round_key_addr = vecs[i].addr;
      #1;
      check($sformatf("vec%0d_key", i), bus.round_key, vecs[i].exp);
    end

    start({V128, 128'h0}, 1'b0);
    model_expand({V128, 128'h0}, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    bus.init = 1'b1;
    bus.key = ~V256;
    bus.keylen = 1'b1;
    @(posedge clk);
    #1;
    bus.init = 1'b0;
    wait_ready("ign", 6, 12);
    check_addrs("ign", 0, 10);

    start(V256, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rst_mid_ready", 128'(bus.ready), 128'd1);
    model_clear();
    check_addrs("rst_mid", 0, 15);
    @(negedge clk);
    reset = 1'b0;
    run("after_rst", V256, 1'b1);
    check_addrs("after_rst", 0, 15);

    rk = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    run("stale256", rk, 1'b1);
    rk = {$urandom(), $urandom(), $urandom(), $urandom(),
          $urandom(), $urandom(), $urandom(), $urandom()};
    run("stale128", rk, 1'b0);
    check_addrs("stale", 0, 15);

    for (int it = 0; it < 6; it++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      rl = 1'($urandom_range(0, 1));
      run($sformatf("rnd%0d", it), rk, rl);
      check_addrs($sformatf("rnd%0d", it), 0, 15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
